// File: rtl/int_control.sv
// Fixed-priority 8051 interrupt controller: registered one-hot grant plus a
// TCON copy with the hardware-acknowledged flag of the granted source cleared.
module int_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IE,
  input  logic [7:0] TCON,
  input  logic [1:0] SCON,
  output logic [4:0] interupt,
  output logic [7:0] TCON_out
);

  logic [4:0] req_raw;
  logic [4:0] req;
  logic [4:0] grant_d;
  logic [4:0] grant_q;
  logic [7:0] tcon_d;
  logic [7:0] tcon_q;

  // Source index order doubles as priority order: bit 0 is highest.
  assign req_raw[0] = TCON[1] & IE[0];
  assign req_raw[1] = TCON[5] & IE[1];
  assign req_raw[2] = TCON[3] & IE[2];
  assign req_raw[3] = TCON[7] & IE[3];
  assign req_raw[4] = (SCON[1] | SCON[0]) & IE[4];

  assign req = IE[7] ? req_raw : 5'b00000;

  // Isolate the lowest set bit, i.e. the highest-priority pending request.
  assign grant_d = req & (~req + 5'd1);

  always_comb begin
    tcon_d = TCON;
    if (grant_d[0] && TCON[0]) tcon_d[1] = 1'b0;
    if (grant_d[1])            tcon_d[5] = 1'b0;
    if (grant_d[2] && TCON[2]) tcon_d[3] = 1'b0;
    if (grant_d[3])            tcon_d[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      grant_q <= 5'b00000;
      tcon_q  <= 8'h00;
    end else begin
      grant_q <= grant_d;
      tcon_q  <= tcon_d;
    end
  end

  assign interupt = grant_q;
  assign TCON_out = tcon_q;

endmodule

// File: tb/tb_int_control.sv
// Bench for int_control: directed steps from the plan, then random traffic
// compared against a priority-table reference model.
module tb_int_control;

  logic       clk;
  logic       rst_n;
  logic [7:0] IE;
  logic [7:0] TCON;
  logic [1:0] SCON;
  logic [4:0] interupt;
  logic [7:0] TCON_out;

  int n_checks = 0;
  int n_fail   = 0;

  int_control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IE       (IE),
    .TCON     (TCON),
    .SCON     (SCON),
    .interupt (interupt),
    .TCON_out (TCON_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the sources in priority order; first pending+enabled wins.
  task automatic model(input logic [7:0] ie, input logic [7:0] tcon,
                       input logic [1:0] scon,
                       output logic [4:0] g, output logic [7:0] t);
    int flag_bit [4] = '{1, 5, 3, 7};
    int mode_bit [4] = '{0, -1, 2, -1};
    logic pend;
    g = 5'b0;
    t = tcon;
    if (ie[7]) begin
      for (int s = 0; s < 5; s++) begin
        pend = (s == 4) ? ((scon != 2'b00) && ie[4])
                        : (tcon[flag_bit[s]] && ie[s]);
        if (pend) begin
          g[s] = 1'b1;
          if (s < 4) begin
            if (mode_bit[s] < 0 || tcon[mode_bit[s]])
              t[flag_bit[s]] = 1'b0;
          end
          break;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, then sample the registered outputs.
  task automatic step(input logic [7:0] ie, input logic [7:0] tcon, input logic [1:0] scon);
    IE = ie; TCON = tcon; SCON = scon;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] g, input logic [7:0] t);
    check({tag, ".int"}, {3'b0, interupt}, {3'b0, g});
    check({tag, ".tcon"}, TCON_out, t);
    $display("%s: IE=%h TCON=%h SCON=%b -> interupt=%b TCON_out=%h", tag, IE, TCON, SCON, interupt, TCON_out);
  endtask

  initial begin
    logic [4:0] eg;
    logic [7:0] et;
    logic [7:0] ie_r, tc_r;
    logic [1:0] sc_r;

    rst_n = 1'b1;
    IE = 'x; TCON = 'x; SCON = 'x;
    @(posedge clk); #1;
    expect_out("reset_x", 5'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(8'h9F, 8'hAA, 2'b11);
      expect_out("reset_hold", 5'b0, 8'h00);
    end
    rst_n = 1'b0;
    step(8'h9F, 8'hAA, 2'b11);
    expect_out("after_reset", 5'b00001, 8'hAA);

    step(8'h1F, 8'hAA, 2'b11);
    expect_out("ea_off", 5'b00000, 8'hAA);

    step(8'h82, 8'h30, 2'b00);
    expect_out("timer0", 5'b00010, 8'h10);

    step(8'h84, 8'h0C, 2'b00);
    expect_out("int1_edge", 5'b00100, 8'h04);
    step(8'h84, 8'h08, 2'b00);
    expect_out("int1_level", 5'b00100, 8'h08);

    step(8'h81, 8'h03, 2'b00);
    expect_out("int0_edge", 5'b00001, 8'h01);

    step(8'h88, 8'hC0, 2'b00);
    expect_out("timer1", 5'b01000, 8'h40);

    step(8'h9F, 8'hA8, 2'b01);
    expect_out("prio_t0", 5'b00010, 8'h88);
    step(8'h9F, 8'h88, 2'b01);
    expect_out("prio_int1", 5'b00100, 8'h88);

    for (int i = 0; i < 3; i++) begin
      step(8'h90, 8'h00, 2'b10);
      expect_out("serial_rep", 5'b10000, 8'h00);
    end

    for (int i = 0; i < 400; i++) begin
      ie_r = 8'($urandom);
      tc_r = 8'($urandom);
      sc_r = 2'($urandom);
      if ((i % 4) == 0) ie_r[7] = 1'b1;
      if (i == 200) begin
        rst_n = 1'b1;
        step(ie_r, tc_r, sc_r);
        expect_out("mid_reset", 5'b0, 8'h00);
        rst_n = 1'b0;
      end
      step(ie_r, tc_r, sc_r);
      model(ie_r, tc_r, sc_r, eg, et);
      expect_out("rand", eg, et);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
